// File: rtl/pixel_fetch_scheduler.sv
// pixel_fetch_scheduler: per-scanline framebuffer burst fetcher feeding a first-word-fall-through FIFO.
// Define PIXEL_FETCH_STATS_EN to add the saturating starve_count statistics counter.
module pixel_fetch_scheduler #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int PIX_W      = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [PIX_W-1:0]  pixels_per_line,
  input  logic              mode32,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_strobe,
  output logic              busy,
  output logic              line_overrun,
  output logic [15:0]       starve_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int WW = PIX_W + 2;
  typedef enum logic [1:0] {IDLE, ISSUE, ABORT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, base_q, base_d, mem_addr_q, mem_addr_d;
  logic [WW-1:0] remaining_q, remaining_d, keep_q, keep_d, words, quads, burst_n;
  logic [CW-1:0] outstanding_q, outstanding_d, count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic mem_req_q, mem_req_d, overrun_q, overrun_d;
  logic acc, push, pop, flush, abort_exit, space_ok, raise;
  // Packed mode drops pixels_per_line[1:0] so the unpacker realigns each line.
  assign quads      = {2'b00, pixels_per_line} >> 2;
  assign words      = mode32 ? {2'b00, pixels_per_line} : quads + (quads << 1);
  assign burst_n    = remaining_q < WW'(BURST_LEN) ? remaining_q : WW'(BURST_LEN);
  assign acc        = mem_req_q & mem_ack;
  assign space_ok   = SW'(count_q) + SW'(outstanding_q) + SW'(BURST_LEN) <= SW'(FIFO_DEPTH);
  assign raise      = state_q == ISSUE && !frame_start && remaining_q != '0 && space_ok;
  assign mem_req_d  = mem_req_q ? !mem_ack : raise;
  assign mem_addr_d = (!mem_req_q && raise) ? cur_addr_q : mem_addr_q;
  assign abort_exit = state_q == ABORT && !mem_req_q && outstanding_q == '0;
  assign flush      = frame_start | abort_exit;
  assign push       = mem_rvalid & (keep_q != '0);
  assign pop        = word_strobe & word_valid;
  assign word_valid   = count_q != '0;
  assign word_out     = word_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy         = state_q != IDLE || word_valid;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign line_overrun = overrun_q;
  assign outstanding_d = outstanding_q + (acc ? CW'(BURST_LEN) : '0) - CW'(mem_rvalid);
  assign count_d       = flush ? '0 : count_q + CW'(push) - CW'(pop);
  assign wr_ptr_d      = flush ? '0 : wr_ptr_q + AW'(push);
  assign rd_ptr_d      = flush ? '0 : rd_ptr_q + AW'(pop);
  assign base_d        = frame_start ? base_addr : base_q;
  assign overrun_d     = frame_start ? 1'b0 : overrun_q | (line_start & busy);
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = acc ? cur_addr_q + ADDR_W'(burst_n) : cur_addr_q;
    remaining_d = acc ? remaining_q - burst_n : remaining_q;
    keep_d      = push ? keep_q - WW'(1) : keep_q;
    if (frame_start) begin
      state_d     = ABORT;
      keep_d      = '0;
      remaining_d = '0;
    end else if (state_q == IDLE && line_start && !busy && words != '0) begin
      state_d     = ISSUE;
      remaining_d = words;
      keep_d      = words;
    end else if (state_q == ISSUE && remaining_q == '0 && outstanding_q == '0) begin
      state_d = IDLE;
    end else if (abort_exit) begin
      state_d    = IDLE;
      cur_addr_d = base_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      base_q        <= '0;
      mem_addr_q    <= '0;
      remaining_q   <= '0;
      keep_q        <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_req_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      base_q        <= base_d;
      mem_addr_q    <= mem_addr_d;
      remaining_q   <= remaining_d;
      keep_q        <= keep_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_req_q     <= mem_req_d;
      overrun_q     <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr_q] <= mem_rdata;
  end
`ifdef PIXEL_FETCH_STATS_EN
  logic [15:0] starve_q;
  always_ff @(posedge clk) begin
    if (!reset_n || frame_start) starve_q <= '0;
    else if (state_q == ISSUE && keep_q != '0 && !word_valid && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
  end
  assign starve_count = starve_q;
`else
  assign starve_count = '0;
`endif
endmodule

// File: doc/pixel_fetch_scheduler.md
Name: pixel_fetch_scheduler

Overview:
- Sequences framebuffer reads for the video output path.
- Per scanline: computes the 32-bit word count, issues fixed-length burst reads to the memory arbiter, and buffers returned words in a FIFO.
- Serves the FIFO pull-based to the downstream 24-bit unpacker (word_out/word_valid/word_strobe map to its in32/input_valid/strobe_input).
- Tracks the linear line address across a frame.

Parameters:
ADDR_W, 22, memory word address width (32-bit words)
FIFO_DEPTH, 16, output FIFO depth in words; power of two, >= 2*BURST_LEN
BURST_LEN, 4, words per memory burst; power of two
PIX_W, 12, width of the pixels_per_line field

Ports:
clk  in  1  system clock
reset_n  in  1  reset
frame_start  in  1  one-cycle pulse: abort any fetch, reload the address from base_addr
line_start  in  1  one-cycle pulse: fetch one scanline
base_addr  in  ADDR_W  frame base word address, sampled at frame_start
pixels_per_line  in  PIX_W  pixels per line, sampled at line_start
mode32  in  1  1 = one pixel per word; 0 = packed 24-bit pixels, sampled at line_start
mem_req  out  1  burst request
mem_addr  out  ADDR_W  burst start word address
mem_ack  in  1  request accepted this cycle
mem_rdata  in  32  read data
mem_rvalid  in  1  one returned word this cycle
word_out  out  32  FIFO head word
word_valid  out  1  FIFO not empty
word_strobe  in  1  pop the FIFO head
busy  out  1  line fetch, abort or FIFO drain in progress
line_overrun  out  1  sticky: line_start arrived while busy
starve_count  out  16  see Optional Feature

Behaviour:
- Reset: synchronous, active-low on reset_n; everything else clocked on the rising edge of clk.
- Reset values: all outputs 0, FIFO empty, cur_addr 0, state IDLE, all counters 0.
- Word count W:
  - mode32=1: W = pixels_per_line.
  - mode32=0: W = 3*(pixels_per_line>>2); pixels_per_line[1:0] ignored so the unpacker phase realigns at every line.
  - Computed with PIX_W+2 bits.
- States: IDLE, ISSUE, ABORT.
- IDLE:
  - line_start loads remaining=W and keep=W, then goes to ISSUE.
  - If W=0, stay in IDLE and raise no busy.
- ISSUE:
  - Raise mem_req (mem_addr=cur_addr) when remaining>0 and FIFO_DEPTH - fifo_count - outstanding >= BURST_LEN.
  - Once raised, mem_req and mem_addr stay stable until mem_ack; they are never withdrawn.
  - On ack: n = min(BURST_LEN, remaining); cur_addr += n; remaining -= n; outstanding += BURST_LEN.
  - When remaining=0 and outstanding=0, go to IDLE.
- Returned data:
  - Each mem_rvalid decrements outstanding.
  - The word is written to the FIFO only if keep>0 (then keep -= 1); over-fetched tail words are dropped.
  - Next line starts at the word after the last kept word.
- Simultaneous ack and rvalid in one cycle: outstanding += BURST_LEN-1.
- FIFO:
  - First-word-fall-through; word_out is valid whenever word_valid=1.
  - word_strobe with word_valid=0 is ignored.
  - Push and pop in the same cycle leaves fifo_count unchanged.
  - The FIFO never overflows by construction; space is reserved at request time.
- busy = (state != IDLE) || word_valid.
- line_start while busy: ignored; sets line_overrun.
- frame_start (any state):
  - Clears line_overrun; enters ABORT; further bursts suppressed.
  - A raised mem_req is held until its mem_ack, which adds BURST_LEN to outstanding.
  - FIFO flushed immediately and again on ABORT exit; keep=0.
  - ABORT exits to IDLE when mem_req=0 and outstanding=0; cur_addr=base_addr is loaded on exit.
  - frame_start in IDLE reaches IDLE again after 1 cycle.
- frame_start and line_start in the same cycle: frame_start wins; line_start dropped and line_overrun not set.

Optional Feature:
- Macro: PIXEL_FETCH_STATS_EN.
- Defined:
  - starve_count increments (saturating at 16'hFFFF) each cycle where state=ISSUE, keep>0 and word_valid=0.
  - Cleared at frame_start and reset.
- Undefined: starve_count is constant 0 and the counter logic is absent.

Test Plan:
- base_addr=0x1000, frame_start, line_start, mode32=1, pixels=8, 1-cycle ack, data 2 cycles after ack -> requests at 0x1000 and 0x1004, 8 words in order, cur_addr=0x1008, busy falls after last pop.
- mode32=0, pixels=8 -> W=6; bursts at 0x1000 and 0x1004; last 2 returned words dropped; next line's first request at 0x1006.
- Hold word_strobe=0, pixels=64, mode32=1 -> at most FIFO_DEPTH words fetched and mem_req stays low; releasing strobe resumes bursts and no word is lost.
- line_start while busy -> ignored, line_overrun=1; next frame_start clears it.
- frame_start while 4 words outstanding -> no new req; the 4 words are discarded; word_valid stays 0; IDLE reached after the last rvalid; next request at the new base_addr.
- With PIXEL_FETCH_STATS_EN, memory returns data 10 cycles after ack -> starve_count counts starved cycles; reads 0 after frame_start.
